// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud detector.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    WAIT_START,
    MEASURE,
    CHECK_STOP
  } state_t;

  // 0x55 framed: t0 start fall plus four data falls; the 5th fall is t = 8 bit periods
  localparam int unsigned FALL_TARGET = 5;
  localparam int unsigned TOL_SHIFT   = 2;
  localparam int unsigned DIV_SHIFT   = 4;
  localparam int unsigned DIV_ROUND   = 8;

endpackage

// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the auto-baud detector and its controller.
interface uart_autobaud_if;

  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic        locked;
  logic [15:0] divisor;

  modport master (output start, input busy, done, error, locked, divisor);
  modport slave  (input start, output busy, done, error, locked, divisor);

endinterface

// File: rtl/uart_autobaud_rx_sync_edge.sv
// rx synchroniser chain with single-cycle rise/fall pulses on the synchronised level.
module uart_rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Reset to the idle-high line level so release from reset never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 calibration character and produces the half-bit toggle divisor.
// Build option: AUTOBAUD_REARM_EN keeps the detector armed and retrying after a rejected measurement.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_BIT     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_autobaud_if.slave  ctl
);

  state_t             state;
  logic [CNT_W-1:0]   total;
  logic [CNT_W-1:0]   seg;
  logic [CNT_W-1:0]   ref_len;
  logic [CNT_W-1:0]   meas;
  logic [3:0]         edge_idx;
  logic [2:0]         fall_cnt;

  logic               level;
  logic               rise;
  logic               fall;

  uart_rx_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  logic             any_edge;
  logic [CNT_W-1:0] seg_len;
  logic [CNT_W-1:0] diff;
  logic             tol_ok;
  logic             timeout;
  logic [CNT_W:0]   div_sum;
  logic [CNT_W:0]   div_calc;
  logic             div_bad;
  logic             fail_now;

  always_comb begin
    any_edge = rise | fall;
    seg_len  = seg + 1'b1;
    diff     = (seg_len >= ref_len) ? (seg_len - ref_len) : (ref_len - seg_len);
    tol_ok   = (diff <= (ref_len >> TOL_SHIFT));
    timeout  = ({1'b0, seg} >= {ref_len, 1'b0});
    div_sum  = {1'b0, meas} + (CNT_W+1)'(DIV_ROUND);
    div_calc = div_sum >> DIV_SHIFT;
    div_bad  = (div_calc == '0) || (div_calc > (CNT_W+1)'(16'hFFFF));

    fail_now = 1'b0;
    case (state)
      // Segment 0 has no reference yet; the total-counter saturation bounds it instead
      MEASURE: begin
        if (any_edge)
          fail_now = (edge_idx == '0) ? (seg_len < CNT_W'(MIN_BIT)) : !tol_ok;
        else
          fail_now = ((edge_idx != '0) && timeout) || (total == '1);
      end
      CHECK_STOP: begin
        if (rise)
          fail_now = !tol_ok || div_bad;
        else
          fail_now = timeout;
      end
      default: fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctl.busy    <= 1'b0;
      ctl.done    <= 1'b0;
      ctl.error   <= 1'b0;
      ctl.locked  <= 1'b0;
      ctl.divisor <= DEFAULT_DIV;
      total       <= '0;
      seg         <= '0;
      ref_len     <= '0;
      meas        <= '0;
      edge_idx    <= '0;
      fall_cnt    <= '0;
    end else begin
      ctl.done  <= 1'b0;
      ctl.error <= 1'b0;
      if (fail_now) begin
        ctl.error <= 1'b1;
`ifdef AUTOBAUD_REARM_EN
        state     <= WAIT_HIGH;
`else
        ctl.busy  <= 1'b0;
        state     <= IDLE;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (ctl.start) begin
              ctl.busy   <= 1'b1;
              ctl.locked <= 1'b0;
              state      <= WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            if (level)
              state <= WAIT_START;
          end
          WAIT_START: begin
            if (fall) begin
              total    <= '0;
              seg      <= '0;
              edge_idx <= '0;
              fall_cnt <= 3'd1;
              state    <= MEASURE;
            end
          end
          MEASURE: begin
            total <= total + 1'b1;
            if (any_edge) begin
              seg      <= '0;
              edge_idx <= edge_idx + 1'b1;
              if (edge_idx == '0)
                ref_len <= seg_len;
              if (fall) begin
                fall_cnt <= fall_cnt + 1'b1;
                if (fall_cnt == 3'(FALL_TARGET - 1)) begin
                  meas  <= total + 1'b1;
                  state <= CHECK_STOP;
                end
              end
            end else begin
              seg <= seg + 1'b1;
            end
          end
          CHECK_STOP: begin
            if (rise) begin
              ctl.divisor <= div_calc[15:0];
              ctl.done    <= 1'b1;
              ctl.locked  <= 1'b1;
              ctl.busy    <= 1'b0;
              state       <= IDLE;
            end else begin
              seg <= seg + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: hand-timed 0x55/0x41 frames, jitter, glitch and reset cases.
module tb_uart_autobaud;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  always #5 clk = ~clk;

  uart_autobaud_if bus ();

  uart_autobaud #(
    .CNT_W       (24),
    .SYNC_STAGES (2),
    .MIN_BIT     (4),
    .DEFAULT_DIV (16'd217)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .ctl   (bus)
  );

`ifdef AUTOBAUD_REARM_EN
  localparam int BUSY_AFTER_ERR = 1;
  localparam int ERRS_TRAILING  = 2;
`else
  localparam int BUSY_AFTER_ERR = 0;
  localparam int ERRS_TRAILING  = 1;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int d0;
  int e0;
  int bl [10];

  always @(negedge clk) begin
    if (bus.done === 1'b1)  done_cnt++;
    if (bus.error === 1'b1) err_cnt++;
    if (bus.done === 1'b1 && bus.error === 1'b1) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    step(n);
  endtask

  task automatic set_bits(input int p);
    for (int i = 0; i < 10; i++) bl[i] = p;
  endtask

  // Start bit plus eight data bits LSB first; leaves rx high at the start of the stop bit.
  task automatic send_frame(input logic [7:0] data);
    hold(1'b0, bl[0]);
    for (int i = 0; i < 8; i++) hold(data[i], bl[i+1]);
    rx = 1'b1;
  endtask

  task automatic arm();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    hold(1'b1, 4);
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    rx        = 1'b1;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    step(3);
    check("rst_busy",    bus.busy,    0);
    check("rst_done",    bus.done,    0);
    check("rst_error",   bus.error,   0);
    check("rst_locked",  bus.locked,  0);
    check("rst_divisor", bus.divisor, 217);
    rst_n = 1'b1;
    step(2);

    // 434 clk/bit: meas 3472 -> (3480 >> 4) = 217, done 3 edges after the stop rise on rx
    set_bits(434);
    arm();
    check("t1_busy_armed", bus.busy, 1);
    snap();
    send_frame(8'h55);
    step(2);
    check("t1_done_early", bus.done, 0);
    step(1);
    check("t1_done",    bus.done,    1);
    check("t1_error",   bus.error,   0);
    check("t1_divisor", bus.divisor, 217);
    check("t1_locked",  bus.locked,  1);
    check("t1_busy",    bus.busy,    0);
    step(1);
    check("t1_done_pulse", bus.done, 0);
    check("t1_err_cnt", err_cnt - e0, 0);

    // 5208 clk/bit: meas 41664 -> (41672 >> 4) = 2604
    set_bits(5208);
    arm();
    snap();
    send_frame(8'h55);
    step(10);
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_err_cnt",  err_cnt - e0,  0);
    check("t2_divisor",  bus.divisor,   2604);
    check("t2_locked",   bus.locked,    1);
    check("t2_busy",     bus.busy,      0);

    // Data bit b2 at 560 vs ref 434: |126| > 108 -> reject, divisor keeps 2604
    set_bits(434);
    bl[3] = 560;
    arm();
    check("t3_locked_cleared", bus.locked, 0);
    snap();
    send_frame(8'h55);
    step(1000);
    check("t3_err_cnt",  err_cnt - e0,  ERRS_TRAILING);
    check("t3_done_cnt", done_cnt - d0, 0);
    check("t3_divisor",  bus.divisor,   2604);
    check("t3_locked",   bus.locked,    0);
    check("t3_busy",     bus.busy,      BUSY_AFTER_ERR);

    // Reset while measuring restores every output, including the default divisor
    set_bits(434);
    arm();
    hold(1'b0, 434);
    hold(1'b1, 200);
    check("t4_busy_measuring", bus.busy, 1);
    rst_n = 1'b0;
    step(1);
    check("t4_busy",    bus.busy,    0);
    check("t4_locked",  bus.locked,  0);
    check("t4_divisor", bus.divisor, 217);
    check("t4_done",    bus.done,    0);
    check("t4_error",   bus.error,   0);
    rst_n = 1'b1;
    step(2);

    // Jittered bits within tolerance of ref 434; first eight periods sum to 3474 -> 217
    bl[0] = 434; bl[1] = 500; bl[2] = 370; bl[3] = 480; bl[4] = 388;
    bl[5] = 434; bl[6] = 450; bl[7] = 418; bl[8] = 398; bl[9] = 434;
    arm();
    snap();
    send_frame(8'h55);
    step(10);
    check("t5_done_cnt", done_cnt - d0, 1);
    check("t5_err_cnt",  err_cnt - e0,  0);
    check("t5_divisor",  bus.divisor,   217);
    check("t5_locked",   bus.locked,    1);
    check("t5_busy",     bus.busy,      0);

    // 3-cycle glitch is shorter than MIN_BIT; a start pulse while busy changes nothing
    arm();
    snap();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("t6_busy_held", bus.busy, 1);
    hold(1'b0, 3);
    hold(1'b1, 20);
    check("t6_err_cnt",  err_cnt - e0,  1);
    check("t6_done_cnt", done_cnt - d0, 0);
    check("t6_busy",     bus.busy,      BUSY_AFTER_ERR);
    check("t6_locked",   bus.locked,    0);
    check("t6_divisor",  bus.divisor,   217);

    // 0x41: five-bit low run reaches 2*ref = 868 without an edge -> timeout
    set_bits(434);
    arm();
    snap();
    send_frame(8'h41);
    step(1000);
    check("t7_err_cnt",  err_cnt - e0,  ERRS_TRAILING);
    check("t7_done_cnt", done_cnt - d0, 0);
    check("t7_busy",     bus.busy,      BUSY_AFTER_ERR);
    check("t7_locked",   bus.locked,    0);

`ifdef AUTOBAUD_REARM_EN
    // Still armed after the failures: a clean 0x55 now locks without a new start
    snap();
    send_frame(8'h55);
    step(10);
    check("t8_done_cnt", done_cnt - d0, 1);
    check("t8_err_cnt",  err_cnt - e0,  0);
    check("t8_divisor",  bus.divisor,   217);
    check("t8_locked",   bus.locked,    1);
    check("t8_busy",     bus.busy,      0);
`endif

    check("done_error_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Measures the bit period of an incoming calibration character 0x55 ('U') on the UART rx line.
- Produces the 16-bit toggle divisor for the baud generator: half-bit-period count in clk cycles.
- Sits between the rx pad synchroniser path and the baud generator divisor input.
- Armed by software or a controller; reports done, error and a sticky locked flag.

Parameters:
- CNT_W, 24, width of the total and segment cycle counters.
- SYNC_STAGES, 2, number of flip-flops in the rx synchroniser chain (minimum 2).
- MIN_BIT, 4, minimum accepted bit period in clk cycles; shorter periods are treated as glitches.
- DEFAULT_DIV, 16'd217, divisor value driven out of reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle arm request; ignored while busy=1.
- rx  in  1  asynchronous serial line, idle high.
- busy  out  1  high from arm until done or error.
- done  out  1  one-cycle pulse; measurement accepted.
- error  out  1  one-cycle pulse; measurement rejected.
- locked  out  1  sticky success flag.
- divisor  out  16  toggle divisor (half-bit count).

Behaviour:
- Reset values: busy=0, done=0, error=0, locked=0, divisor=DEFAULT_DIV; FSM=IDLE; all counters cleared.
- rx passes through SYNC_STAGES flops. Edge detection runs on the synchronised value. The synchroniser latency is identical on every edge, so it cancels out of all measurements.
- IDLE: start=1 -> WAIT_HIGH. In the same cycle: busy<=1, locked<=0.
- WAIT_HIGH: synchronised rx=1 -> WAIT_START. Prevents arming mid-character.
- WAIT_START: falling edge -> MEASURE. Clear total and seg; edge_idx=0. No timeout in this state.
- MEASURE: total and seg increment every cycle. Each edge (either polarity) closes a segment.
  - Segment 0 is the start bit. Store ref=seg+1. If ref<MIN_BIT -> error.
  - Segments 1..7: reject if |seg+1 - ref| > (ref>>2), i.e. 25% tolerance -> error.
  - The 5th falling edge (t = 8 bit periods) closes segment 7. Latch the total for t0..t8 into meas and go to CHECK_STOP.
- CHECK_STOP: the rising edge (start of stop bit) closes segment 8 and gets the same tolerance check. On pass:
  - div_calc = (meas + 8) >> 4, i.e. 8 bits / 2, rounded.
  - If div_calc==0 or div_calc>16'hFFFF -> error.
  - Otherwise: divisor<=div_calc, done<=1, locked<=1, busy<=0 -> IDLE.
- Timeout (MEASURE and CHECK_STOP): if seg reaches 2*ref without an edge -> error. Covers a stuck line or a wrong character.
- Counter saturation: if total reaches all-ones -> error.
- Error exit: error pulse, busy<=0, locked stays 0, divisor unchanged -> IDLE.
- Simultaneous events:
  - start while busy: ignored.
  - done/error and start in the same cycle: start ignored, since busy is still 1 that cycle.
- Reset mid-operation: everything returns to reset values, including divisor=DEFAULT_DIV.
- done and error are never both asserted.

Optional Feature:
- Macro AUTOBAUD_REARM_EN.
- Defined: on any error, error still pulses for one cycle, but the FSM goes to WAIT_HIGH and busy stays 1. Retries continue until success or reset.
- Undefined: error returns to IDLE as specified above.

Decomposition:
- Package uart_autobaud_pkg holds:
  - state enum {IDLE, WAIT_HIGH, WAIT_START, MEASURE, CHECK_STOP};
  - FALL_TARGET=5, TOL_SHIFT=2, DIV_SHIFT=4, DIV_ROUND=8.
- One sub-module: uart_rx_sync_edge (SYNC_STAGES synchroniser plus rise/fall pulse outputs), reusable by the UART receiver.

Test Plan:
- 0x55 at 434 clk/bit after start -> meas=3472; done one cycle after the stop-bit rising edge (plus sync latency); divisor=217; locked=1; busy=0.
- 0x55 at 5208 clk/bit -> meas=41664; divisor=2604; no error pulse.
- Per-bit jitter within ±20% around 434 -> done, divisor within ±1 of 217. One data bit at 560 (>25% off) -> error; divisor holds prior value; locked=0.
- 0x41 sent at 434 clk/bit -> 5-bit low run exceeds 868 cycles -> error; with AUTOBAUD_REARM_EN, busy stays 1 and a following 0x55 yields done with divisor=217.
- 3-cycle low glitch after arm -> ref<MIN_BIT -> error; start pulsed while busy has no effect.
- rst_n=0 during MEASURE -> next cycle busy=0, locked=0, divisor=217 (DEFAULT_DIV), done=error=0.
